// File: rtl/ones_pattern_gen.sv
// Builds a WIDTH-bit vector holding exactly N contiguous ones from bit S,
// wrapping mod WIDTH, filled CHUNK bits per cycle.
module ones_pattern_gen #(
   parameter int WIDTH = 127,
   parameter int CW    = 7,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [CW-1:0]    in_count,
   input  logic [CW-1:0]    in_start,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_vec,
   output logic [CW-1:0]    out_count,
   output logic             busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] FILL = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [CW:0] WEXT = (CW+1)'(WIDTH);
   localparam logic [CW:0] CEXT = (CW+1)'(CHUNK);

   logic [1:0]       state;
   logic [CW-1:0]    rem;
   logic [CW-1:0]    pos;
   logic [WIDTH-1:0] vec;
   logic [CW-1:0]    cnt;

   logic [CW:0]      n_ext;
   logic [CW:0]      s_ext;
   logic [CW:0]      k;
   logic [CW:0]      pos_sum;
   logic [CW:0]      off;
   logic [CW-1:0]    rem_nxt;
   logic [WIDTH-1:0] mask;

   always_comb begin
      n_ext = {1'b0, in_count};
      if (n_ext > WEXT)
         n_ext = WEXT;
      s_ext = {1'b0, in_start};
      if (s_ext >= WEXT)
         s_ext = s_ext - WEXT;

      k = ({1'b0, rem} < CEXT) ? {1'b0, rem} : CEXT;
      rem_nxt = rem - k[CW-1:0];

      pos_sum = {1'b0, pos} + k;
      if (pos_sum >= WEXT)
         pos_sum = pos_sum - WEXT;

      // bit j is in this chunk when its distance above pos (mod WIDTH) is < k
      mask = '0;
      off  = '0;
      for (int j = 0; j < WIDTH; j++) begin
         if ((CW+1)'(j) >= {1'b0, pos})
            off = (CW+1)'(j) - {1'b0, pos};
         else
            off = (CW+1)'(j) + WEXT - {1'b0, pos};
         mask[j] = (off < k);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         rem   <= '0;
         pos   <= '0;
         vec   <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  vec   <= '0;
                  cnt   <= n_ext[CW-1:0];
                  rem   <= n_ext[CW-1:0];
                  pos   <= s_ext[CW-1:0];
                  state <= (n_ext == '0) ? DONE : FILL;
               end
            end
            FILL: begin
               vec <= vec | mask;
               rem <= rem_nxt;
               pos <= pos_sum[CW-1:0];
               if (rem_nxt == '0)
                  state <= DONE;
            end
            DONE: begin
               if (out_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign out_vec   = vec;
   assign out_count = cnt;

endmodule

// File: tb/tb_ones_pattern_gen.sv
// Self-checking bench for ones_pattern_gen: directed table, corner
// sequences and random requests against a behavioural model.
module tb_ones_pattern_gen;

   localparam int WIDTH = 127;
   localparam int CW    = 7;
   localparam int CHUNK = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [CW-1:0]    in_count;
   logic [CW-1:0]    in_start;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_vec;
   logic [CW-1:0]    out_count;
   logic             busy;

   int n_vec = 0;
   int n_err = 0;

   ones_pattern_gen #(.WIDTH(WIDTH), .CW(CW), .CHUNK(CHUNK)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_count(in_count), .in_start(in_start),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_vec(out_vec), .out_count(out_count),
      .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int               n;
      int               s;
      logic [WIDTH-1:0] vec;
      int               lat;
   } vec_t;

   vec_t tbl[7];

   task automatic chk(input string name, input logic [127:0] act,
                      input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // N ones from S upward, wrapping mod WIDTH
   function automatic logic [WIDTH-1:0] model(input int n, input int s);
      logic [WIDTH-1:0] v;
      v = '0;
      for (int i = 0; i < n; i++)
         v[(s % WIDTH + i) % WIDTH] = 1'b1;
      return v;
   endfunction

   // accept one request (DUT assumed idle) and wait for out_valid
   task automatic do_req(input int n, input int s, output int lat);
      in_valid = 1'b1;
      in_count = CW'(n);
      in_start = CW'(s);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("idle_after_hs", 128'(in_ready), 128'(1));
   endtask

   initial begin
      int lat;
      int n;
      int s;
      logic [WIDTH-1:0] held;
      logic seen;

      tbl[0] = '{0,   5,   '0,                              0};
      tbl[1] = '{10,  0,   127'h3FF,                        2};
      tbl[2] = '{4,   125, 127'h3 | (127'h3 << 125),        1};
      tbl[3] = '{127, 60,  {WIDTH{1'b1}},                   16};
      tbl[4] = '{8,   120, (127'h7F << 120) | 127'h1,       1};
      tbl[5] = '{1,   127, 127'h1,                          1};
      tbl[6] = '{9,   126, (127'h1 << 126) | 127'hFF,       2};

      rst = 1'b1;
      in_valid = 1'b0;
      in_count = '0;
      in_start = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_in_ready", 128'(in_ready), 128'(1));
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_out_vec", 128'(out_vec), 128'(0));
      chk("rst_out_count", 128'(out_count), 128'(0));

      for (int i = 0; i < 7; i++) begin
         do_req(tbl[i].n, tbl[i].s, lat);
         chk($sformatf("tbl%0d_lat", i), 128'(lat), 128'(tbl[i].lat));
         chk($sformatf("tbl%0d_vec", i), 128'(out_vec), 128'(tbl[i].vec));
         chk($sformatf("tbl%0d_cnt", i), 128'(out_count), 128'(tbl[i].n));
         handshake();
      end

      // hold out_ready low: result must stay put
      do_req(10, 0, lat);
      held = out_vec;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("hold_valid", 128'(out_valid), 128'(1));
         chk("hold_vec", 128'(out_vec), 128'(127'h3FF));
      end
      handshake();
      chk("idle_keeps_vec", 128'(out_vec), 128'(held));

      // reset in the middle of a fill
      in_valid = 1'b1;
      in_count = CW'(100);
      in_start = CW'(7);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("mrst_out_valid", 128'(out_valid), 128'(0));
      chk("mrst_out_vec", 128'(out_vec), 128'(0));
      chk("mrst_in_ready", 128'(in_ready), 128'(1));
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         seen |= out_valid;
      end
      chk("mrst_no_output", 128'(seen), 128'(0));

      // back-to-back with in_valid held high
      in_valid = 1'b1;
      in_count = CW'(20);
      in_start = CW'(3);
      @(posedge clk);
      #1;
      in_count = CW'(5);
      in_start = CW'(9);
      chk("b2b_busy", 128'(busy), 128'(1));
      chk("b2b_not_ready", 128'(in_ready), 128'(0));
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("b2b_a_lat", 128'(lat), 128'(3));
      chk("b2b_a_cnt", 128'(out_count), 128'(20));
      chk("b2b_a_vec", 128'(out_vec), 128'(model(20, 3)));
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("b2b_idle", 128'(in_ready), 128'(1));
      chk("b2b_idle_vec", 128'(out_vec), 128'(model(20, 3)));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("b2b_b_busy", 128'(busy), 128'(1));
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("b2b_b_lat", 128'(lat), 128'(1));
      chk("b2b_b_cnt", 128'(out_count), 128'(5));
      chk("b2b_b_vec", 128'(out_vec), 128'(model(5, 9)));
      handshake();

      for (int i = 0; i < 1000; i++) begin
         n = int'($urandom_range(0, WIDTH));
         s = int'($urandom_range(0, WIDTH));
         do_req(n, s, lat);
         chk("rnd_lat", 128'(lat), 128'((n + CHUNK - 1) / CHUNK));
         chk("rnd_vec", 128'(out_vec), 128'(model(n, s)));
         chk("rnd_pop", 128'($countones(out_vec)), 128'(out_count));
         chk("rnd_cnt", 128'(out_count), 128'(n));
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
         handshake();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
